at_resp_parser: RTL and testbench

//  Receive-side decoder for the GSM modem link. Consumes the byte stream from the UART receiver,

---
 rtl/at_resp_parser_if.sv | 12 +
 rtl/at_resp_parser.sv | 121 ++++++++++++
 tb/tb_at_resp_parser.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/at_resp_parser_if.sv
// at_resp_parser_if: byte stream in, decoded response code and message index out
interface at_resp_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ctrl_rst;
  logic [2:0] ctrl;
  logic [7:0] msg_no;
  logic       code_stb;
  logic       line_ovf;
  modport master (output rx_data, rx_valid, ctrl_rst, input ctrl, msg_no, code_stb, line_ovf);
  modport slave  (input rx_data, rx_valid, ctrl_rst, output ctrl, msg_no, code_stb, line_ovf);
endinterface

// File: rtl/at_resp_parser.sv
// at_resp_parser: splits modem RX bytes into lines and classifies them into ctrl codes
module at_resp_parser #(
  parameter int MAX_LINE = 32,
  parameter int IDLE_CYC = 50000
) (
  input logic clk,
  input logic rst,
  at_resp_parser_if.slave bus
);
  localparam int PW = $clog2(MAX_LINE + 2);
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;
  // candidates 0..4: OK, ERROR, +CMS ERROR, +CPMS:, +CMTI: (left-aligned, space padded)
  localparam logic [4:0][79:0] STRS = {"+CMTI:    ", "+CPMS:    ", "+CMS ERROR", "ERROR     ", "OK        "};
  localparam int LENS [5] = '{2, 5, 10, 6, 6};
  localparam logic [4:0] PFX = 5'b11100;

  typedef enum logic [1:0] {S_LINE, S_MATCH, S_IDX, S_SKIP} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [IW-1:0] idle;
  logic [4:0]    mask;
  logic          comma;
  logic [1:0]    ndig;
  logic [7:0]    tmp;
  logic [PW-1:0] cpos;
  logic [4:0]    base, nmask, full;
  logic [2:0]    fcode;
  logic          is_digit;
  int            cp;

  always_comb begin
    cpos = (state == S_LINE) ? '0 : pos;
    base = (state == S_LINE) ? '1 : mask;
    cp = (int'(cpos) > 9) ? 9 : int'(cpos);
    nmask = '0;
    full = '0;
    for (int k = 0; k < 5; k++) begin
      nmask[k] = base[k] && ((int'(cpos) < LENS[k]) ? (bus.rx_data == STRS[k][8*(9-cp) +: 8]) : PFX[k]);
      full[k] = mask[k] && (int'(pos) >= LENS[k]);
    end
  end

  assign fcode = full[0] ? 3'b001 : (full[1] | full[2]) ? 3'b011 : full[3] ? 3'b010 : 3'b000;
  assign is_digit = (bus.rx_data >= "0") && (bus.rx_data <= "9");

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LINE;
      pos <= '0;
      idle <= '0;
      mask <= '0;
      comma <= 1'b0;
      ndig <= '0;
      tmp <= 8'h30;
      bus.ctrl <= 3'b000;
      bus.msg_no <= 8'h30;
      bus.code_stb <= 1'b0;
      bus.line_ovf <= 1'b0;
    end else begin
      bus.code_stb <= 1'b0;
      bus.line_ovf <= 1'b0;
      if (bus.ctrl_rst) bus.ctrl <= 3'b000;
      if (bus.rx_valid || state == S_LINE) idle <= '0;
      else if (idle == IW'(IDLE_CYC - 1)) begin
        idle <= '0;
        state <= S_LINE;
        pos <= '0;
        bus.line_ovf <= 1'b1;
      end else idle <= idle + IW'(1);
      // posts below come after the ctrl_rst clear so a new code wins
      if (bus.rx_valid && bus.rx_data != CR) begin
        if (bus.rx_data == LF) begin
          if (state == S_MATCH && |full[3:0]) begin
            bus.ctrl <= fcode;
            bus.code_stb <= 1'b1;
          end
          if (state == S_IDX) begin
            bus.ctrl <= (ndig == 2'd1) ? 3'b100 : 3'b111;
            bus.code_stb <= 1'b1;
            if (ndig == 2'd1) bus.msg_no <= tmp;
          end
          state <= S_LINE;
          pos <= '0;
        end else if (state == S_LINE) begin
          if (bus.rx_data == ">") begin
            bus.ctrl <= 3'b101;
            bus.code_stb <= 1'b1;
          end else begin
            pos <= PW'(1);
            mask <= nmask;
            comma <= 1'b0;
            ndig <= '0;
            state <= |nmask ? S_MATCH : S_SKIP;
          end
        end else if (pos >= PW'(MAX_LINE)) begin
          if (pos == PW'(MAX_LINE)) begin
            bus.line_ovf <= 1'b1;
            pos <= pos + PW'(1);
          end
          state <= S_SKIP;
        end else begin
          pos <= pos + PW'(1);
          if (state == S_MATCH) begin
            mask <= nmask;
            state <= (nmask[4] && pos == PW'(5)) ? S_IDX : |nmask ? S_MATCH : S_SKIP;
          end
          if (state == S_IDX) begin
            if (bus.rx_data == ",") comma <= 1'b1;
            else if (comma && is_digit) begin
              if (ndig == 2'd0) tmp <= bus.rx_data;
              ndig <= (ndig == 2'd2) ? 2'd2 : ndig + 2'd1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_at_resp_parser.sv
// tb_at_resp_parser: scoreboard bench for the modem response line decoder
module tb_at_resp_parser;
  localparam int IDLE = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  at_resp_parser_if bus();
  at_resp_parser #(.MAX_LINE(32), .IDLE_CYC(IDLE)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail = 0;
  int ovf_cnt = 0;
  int o0;
  logic [10:0] sb[$];
  logic [10:0] e;
  logic [7:0] exp_msg = 8'h30;
  string s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_str(input string str);
    for (int i = 0; i < str.len(); i++) send_byte(str[i]);
  endtask

  task automatic expect_code(input logic [2:0] c);
    sb.push_back({c, exp_msg});
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.line_ovf) ovf_cnt++;
    if (bus.code_stb) begin
      chk("sb_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ctrl", 32'(bus.ctrl), 32'(e[10:8]));
        chk("msg_no", 32'(bus.msg_no), 32'(e[7:0]));
      end
    end
  end

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.ctrl_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'(bus.ctrl), 0);
    chk("rst_msg", 32'(bus.msg_no), 32'h30);
    chk("rst_stb", 32'(bus.code_stb), 0);
    chk("rst_ovf", 32'(bus.line_ovf), 0);
    rst = 1'b0;
    expect_code(3'b001);
    send_str("OK\015");
    @(negedge clk);
    bus.rx_data = 8'h0a;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("ok_stb", 32'(bus.code_stb), 1);
    chk("ok_ctrl", 32'(bus.ctrl), 1);
    @(negedge clk);
    chk("stb_width", 32'(bus.code_stb), 0);
    bus.ctrl_rst = 1'b1;
    @(negedge clk);
    bus.ctrl_rst = 1'b0;
    chk("ctrl_rst", 32'(bus.ctrl), 0);
    expect_code(3'b010);
    send_str("AT+CPMS=\"SM\"\015\015\n+CPMS: 0,30,0\015\n");
    chk("cpms_ctrl", 32'(bus.ctrl), 2);
    exp_msg = 8'h37;
    expect_code(3'b100);
    send_str("+CMTI: \"SM\",7\015\n");
    chk("cmti_msg", 32'(bus.msg_no), 32'h37);
    expect_code(3'b111);
    send_str("+CMTI: \"SM\",12\015\n");
    chk("cmti2_msg", 32'(bus.msg_no), 32'h37);
    expect_code(3'b011);
    send_str("+CMS ERROR: 321\015\n");
    send_str("OKAY\015\n");
    chk("okay_keep", 32'(bus.ctrl), 3);
    @(negedge clk) bus.ctrl_rst = 1'b1;
    @(negedge clk) bus.ctrl_rst = 1'b0;
    send_str("\015\n");
    expect_code(3'b011);
    send_str("ERROR\015\n");
    chk("error_ctrl", 32'(bus.ctrl), 3);
    o0 = ovf_cnt;
    for (int i = 0; i < 32; i++) send_byte("A");
    chk("ovf_early", ovf_cnt, o0);
    send_byte("A");
    chk("ovf_33", ovf_cnt, o0 + 1);
    for (int i = 0; i < 7; i++) send_byte("A");
    send_str("\015\n");
    chk("ovf_once", ovf_cnt, o0 + 1);
    chk("ovf_nocode", 32'(bus.ctrl), 3);
    o0 = ovf_cnt;
    s = "+CPMS:";
    for (int i = 0; i < 26; i++) s = {s, "X"};
    expect_code(3'b010);
    send_str(s);
    send_str("\015\n");
    chk("len32_noovf", ovf_cnt, o0);
    o0 = ovf_cnt;
    send_str("OK");
    repeat (IDLE + 10) @(negedge clk);
    chk("idle_ovf", ovf_cnt, o0 + 1);
    expect_code(3'b001);
    send_str("OK\015\n");
    chk("after_idle", 32'(bus.ctrl), 1);
    expect_code(3'b101);
    @(negedge clk);
    bus.rx_data = ">";
    bus.rx_valid = 1'b1;
    bus.ctrl_rst = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.ctrl_rst = 1'b0;
    chk("prompt_ctrl", 32'(bus.ctrl), 5);
    send_str("+CM");
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'(bus.ctrl), 0);
    chk("mid_rst_msg", 32'(bus.msg_no), 32'h30);
    chk("mid_rst_stb", 32'(bus.code_stb), 0);
    @(negedge clk) rst = 1'b0;
    exp_msg = 8'h30;
    send_str("TI: \"SM\",5\015\n");
    expect_code(3'b001);
    send_str("OK\015\n");
    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
